dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
- Memory-side responder for the load/store control signals produced by the decode stage: mem_read, mem_write, byte-mask size and unsigned flag.
- Turns each access into a word-aligned request on the DMEM bus with a req/gnt/rvalid handshake, using byte enables and lane-shifted write data.
- For loads, extracts the addressed bytes and sign- or zero-extends them into a 32-bit result.
- Stalls the core pipeline while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, bus data width; fixed at 32 (4 byte lanes).

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  asynchronous reset, active-high
- i_mem_read  in  1  load request from decode/control
- i_mem_write  in  1  store request from decode/control
- i_d_size  in  4  byte mask: 0001 byte, 0011 half, 1111 word, 0000 none
- i_d_unsigned  in  1  zero-extend load result when 1
- i_addr  in  ADDR_W  effective byte address from the ALU
- i_wdata  in  32  store data (rs2), right-aligned
- o_stall  out  1  holds the pipeline; request inputs stay stable while high
- o_done  out  1  one-cycle pulse when the access completes
- o_load_data  out  32  extended load result, valid while o_done=1
- o_dmem_req  out  1  bus request
- o_dmem_we  out  1  1 = write
- o_dmem_be  out  4  byte enables
- o_dmem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
- o_dmem_wdata  out  32  lane-shifted store data
- i_dmem_gnt  in  1  request accepted this cycle
- i_dmem_rvalid  in  1  read data valid
- i_dmem_rdata  in  32  read data word
- o_misaligned  out  1  misalignment flag (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; captured request registers cleared.
- States: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - A valid request is i_mem_read|i_mem_write with i_d_size != 0.
  - On a valid request: capture op, size, unsigned flag, addr[1:0] and word address. Compute be = i_d_size << addr[1:0] (truncated to 4 bits) and wdata = i_wdata << (8*addr[1:0]). Go to REQ.
  - o_stall is combinational: high in IDLE whenever a valid request is present.
- REQ:
  - o_dmem_req=1; o_dmem_we, o_dmem_be, o_dmem_addr and o_dmem_wdata are registered and stable until gnt.
  - Cycle with gnt=1: a write goes to DONE; a read goes to WAIT_R. Request attributes must not change while req is high without gnt.
- WAIT_R:
  - req=0; wait for i_dmem_rvalid (earliest one cycle after gnt; no upper bound).
  - On rvalid:
    - shifted = rdata >> (8*off).
    - mask 0001: byte with bit 7 extended.
    - mask 0011: half with bit 15 extended.
    - mask 1111: word passed through.
    - Extension is zero when the unsigned flag is set, sign otherwise.
  - Register the result and go to DONE.
- DONE:
  - o_done=1, o_stall=0, o_load_data valid (0 for stores); always returns to IDLE next cycle.
  - The pipeline advances on this edge; the next instruction's request is sampled in IDLE.
- o_stall is high in REQ and WAIT_R.
- Minimum latency: store 3 cycles (IDLE, REQ+gnt, DONE); load 4 cycles.
- i_mem_read and i_mem_write both high is illegal; read takes priority.
- i_d_size=0000 (invalid funct3): no bus access, no stall, no o_done.
- rvalid outside WAIT_R is ignored.
- Reset mid-operation: immediate return to IDLE; req drops asynchronously; a later rvalid for the aborted read is ignored.
- No pipelining: at most one outstanding transaction.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, issues no bus request and no stall.
  - o_misaligned pulses for one cycle, registered, in the cycle after the request is seen in IDLE.
  - No o_done is generated.
- Undefined:
  - o_misaligned is tied 0.
  - Misaligned accesses are issued with truncated be, so lanes beyond byte 3 are dropped.
  - Loads extract from the truncated word as specified under Behaviour.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum;
  - size mask constants SIZE_B=4'b0001, SIZE_H=4'b0011, SIZE_W=4'b1111;
  - a load-extend function, which is reusable by a future DMA read path.
- One sub-module, dmem_load_align: combinational shift, mask and extension of the read word, instantiated in WAIT_R.

Test Plan:
- lb, addr 0x1003, rdata 0x80AB_CDEF, gnt immediate, rvalid +1 -> be=1000, o_dmem_addr=0x1000, o_load_data=0xFFFF_FF80, o_done at cycle 4.
- lhu, addr 0x2002, rdata 0x9234_5678 -> be=1100, o_load_data=0x0000_9234; lh same -> 0xFFFF_9234.
- sb, addr 0x0001, wdata 0x0000_00A5, gnt delayed 3 cycles -> be=0010, wdata=0x0000_A500 held stable, o_stall high until DONE, store completes with no rvalid wait.
- sw, addr 0x0004, wdata 0xDEAD_BEEF -> be=1111, wdata unchanged; back-to-back lw follows -> second access sampled in IDLE the cycle after DONE.
- Reset asserted in WAIT_R, then stale rvalid -> outputs 0 immediately, stale rvalid ignored, no o_done.
- With DMEM_MISALIGN_TRAP_EN: lw at 0x0006 -> o_misaligned pulse, no o_dmem_req, o_stall 0. Without the macro: be=1100 issued.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory access path: state encoding,
// byte-mask size constants and the load-extension function.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SIZE_B = 4'b0001;
    localparam logic [3:0] SIZE_H = 4'b0011;
    localparam logic [3:0] SIZE_W = 4'b1111;

    // Kept free of unit state so a future DMA read path can reuse it.
    function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                                input logic [1:0]  off,
                                                input logic [3:0]  size,
                                                input logic        uns);
        logic [31:0] s;
        s = rdata >> {off, 3'b000};
        case (size)
            SIZE_B:  load_extend = {{24{~uns & s[7]}}, s[7:0]};
            SIZE_H:  load_extend = {{16{~uns & s[15]}}, s[15:0]};
            default: load_extend = s;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [3:0] size,
                                           input logic [1:0] off);
        return ((size == SIZE_H) && off[0]) || ((size == SIZE_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_if.sv
// DMEM bus: word-aligned request with req/gnt handshake and rvalid read return.
interface dmem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_load_align.sv
// Combinational lane shift, mask and sign/zero extension of a returned read word.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [3:0]  size,
    input  logic        uns,
    output logic [31:0] data
);
    assign data = load_extend(rdata, off, size, uns);
endmodule

// File: rtl/dmem_access_unit.sv
// Load/store responder: one DMEM transaction at a time, stalls the pipeline meanwhile.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [3:0]        i_d_size,
    input  logic              i_d_unsigned,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_stall,
    output logic              o_done,
    output logic [DATA_W-1:0] o_load_data,
    output logic              o_misaligned,
    dmem_if.master            bus
);
    state_t            state;
    logic              req_q, we_q, uns_q, done_q;
    logic [3:0]        be_q, size_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, load_q;
    logic [31:0]       aligned;
    logic              valid_req, trap;

    assign valid_req = (i_mem_read | i_mem_write) && (i_d_size != 4'b0000);

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis_q;
    assign trap         = valid_req && is_misaligned(i_d_size, i_addr[1:0]);
    assign o_misaligned = mis_q;
`else
    assign trap         = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    assign o_stall = (state == REQ) || (state == WAIT_R) ||
                     ((state == IDLE) && valid_req && !trap);

    dmem_load_align u_align (
        .rdata (bus.rdata),
        .off   (off_q),
        .size  (size_q),
        .uns   (uns_q),
        .data  (aligned)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            done_q  <= 1'b0;
            be_q    <= '0;
            size_q  <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
            mis_q  <= trap && (state == IDLE);
`endif
            case (state)
                IDLE: begin
                    if (valid_req && !trap) begin
                        // Read wins when both strobes are (illegally) high.
                        we_q    <= i_mem_write & ~i_mem_read;
                        size_q  <= i_d_size;
                        uns_q   <= i_d_unsigned;
                        off_q   <= i_addr[1:0];
                        addr_q  <= {i_addr[ADDR_W-1:2], 2'b00};
                        be_q    <= i_d_size << i_addr[1:0];
                        wdata_q <= i_wdata << {i_addr[1:0], 3'b000};
                        req_q   <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (bus.gnt) begin
                        req_q <= 1'b0;
                        if (we_q) begin
                            load_q <= '0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state  <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (bus.rvalid) begin
                        load_q <= aligned;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    load_q <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req     = req_q;
    assign bus.we      = we_q;
    assign bus.be      = be_q;
    assign bus.addr    = addr_q;
    assign bus.wdata   = wdata_q;
    assign o_done      = done_q;
    assign o_load_data = load_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit; acts as the DMEM slave and the decode stage.
module tb_dmem_access_unit;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, d_unsigned;
    logic [3:0]  d_size;
    logic [31:0] addr, wdata;
    logic        stall, done, misaligned;
    logic [31:0] load_data;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_mem_read   (mem_read),
        .i_mem_write  (mem_write),
        .i_d_size     (d_size),
        .i_d_unsigned (d_unsigned),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_stall      (stall),
        .o_done       (done),
        .o_load_data  (load_data),
        .o_misaligned (misaligned),
        .bus          (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one access from its IDLE cycle to o_done; lat is the cycle (IDLE=1) where o_done appeared.
    task automatic run_access(input logic rd, input logic wr, input logic [3:0] sz, input logic un,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                              input int gdly, output logic [3:0] be_o, output logic [31:0] addr_o,
                              output logic [31:0] wdata_o, output logic we_o, output logic [31:0] ld_o,
                              output int lat, output bit stable, output bit hs_ok);
        int cyc;
        mem_read = rd; mem_write = wr; d_size = sz; d_unsigned = un; addr = a; wdata = wd;
        bus.gnt = 1'b0; bus.rvalid = 1'b0;
        stable = 1'b1; hs_ok = 1'b1; lat = -1; ld_o = '0;
        #1;
        if (stall !== 1'b1 || bus.req !== 1'b0) hs_ok = 1'b0;
        step();
        if (bus.req !== 1'b1 || stall !== 1'b1) hs_ok = 1'b0;
        be_o = bus.be; addr_o = bus.addr; wdata_o = bus.wdata; we_o = bus.we;
        for (int i = 0; i < gdly; i++) begin
            step();
            if (bus.req !== 1'b1 || stall !== 1'b1 || bus.be !== be_o || bus.addr !== addr_o ||
                bus.wdata !== wdata_o || bus.we !== we_o) stable = 1'b0;
        end
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0;
        cyc = 3 + gdly;
        if (rd) begin
            if (bus.req !== 1'b0 || stall !== 1'b1) hs_ok = 1'b0;
            bus.rvalid = 1'b1; bus.rdata = rdat;
            step();
            bus.rvalid = 1'b0;
            cyc++;
        end
        for (int i = 0; i < 4 && lat < 0; i++) begin
            if (done === 1'b1) begin
                lat = cyc; ld_o = load_data;
                if (stall !== 1'b0) hs_ok = 1'b0;
            end else begin
                step();
                cyc++;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0; d_size = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_read = 0; mem_write = 0; d_size = 0; d_unsigned = 0; addr = 0; wdata = 0;
        bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0;
        step(); step();
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.req); end
        checks++; if ({stall, done, misaligned} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {stall, done, misaligned}); end
        checks++; if ({bus.we, bus.be, bus.addr, bus.wdata, load_data} !== '0) begin errors++; $display("FAIL reset_regs got nonzero exp 0"); end
        rst = 1'b0;
    endtask

    task automatic test_load_byte();
        logic [3:0] be; logic [31:0] a, wd, ld; logic we; int lat; bit st, hs;
        run_access(1, 0, SIZE_B, 0, 32'h1003, 32'h0, 32'h80AB_CDEF, 0, be, a, wd, we, ld, lat, st, hs);
        checks++; if (be !== 4'b1000) begin errors++; $display("FAIL lb_be got %b exp 1000", be); end
        checks++; if (a !== 32'h1000) begin errors++; $display("FAIL lb_addr got %h exp 00001000", a); end
        checks++; if (ld !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", ld); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL lb_latency got %0d exp 4", lat); end
        checks++; if (!hs || we !== 1'b0) begin errors++; $display("FAIL lb_handshake got hs=%b we=%b exp hs=1 we=0", hs, we); end
        step();
        checks++; if (done !== 1'b0 || load_data !== 32'h0) begin errors++; $display("FAIL lb_done_pulse got done=%b data=%h exp 0", done, load_data); end
        run_access(1, 0, SIZE_B, 1, 32'h0002, 32'h0, 32'h00F0_0000, 0, be, a, wd, we, ld, lat, st, hs);
        checks++; if (ld !== 32'h0000_00F0 || be !== 4'b0100) begin errors++; $display("FAIL lbu_data got %h be %b exp 000000f0 be 0100", ld, be); end
        step();
        run_access(1, 0, SIZE_B, 0, 32'h0002, 32'h0, 32'h00F0_0000, 0, be, a, wd, we, ld, lat, st, hs);
        checks++; if (ld !== 32'hFFFF_FFF0) begin errors++; $display("FAIL lb_neg_data got %h exp fffffff0", ld); end
        step();
    endtask

    task automatic test_load_half();
        logic [3:0] be; logic [31:0] a, wd, ld; logic we; int lat; bit st, hs;
        run_access(1, 0, SIZE_H, 1, 32'h2002, 32'h0, 32'h9234_5678, 0, be, a, wd, we, ld, lat, st, hs);
        checks++; if (be !== 4'b1100 || a !== 32'h2000) begin errors++; $display("FAIL lhu_be_addr got %b %h exp 1100 00002000", be, a); end
        checks++; if (ld !== 32'h0000_9234) begin errors++; $display("FAIL lhu_data got %h exp 00009234", ld); end
        step();
        run_access(1, 0, SIZE_H, 0, 32'h2002, 32'h0, 32'h9234_5678, 0, be, a, wd, we, ld, lat, st, hs);
        checks++; if (ld !== 32'hFFFF_9234) begin errors++; $display("FAIL lh_data got %h exp ffff9234", ld); end
        step();
        run_access(1, 0, SIZE_H, 0, 32'h2000, 32'h0, 32'h9234_5678, 0, be, a, wd, we, ld, lat, st, hs);
        checks++; if (ld !== 32'h0000_5678 || be !== 4'b0011) begin errors++; $display("FAIL lh_low_data got %h be %b exp 00005678 be 0011", ld, be); end
        step();
    endtask

    task automatic test_store_delayed_gnt();
        logic [3:0] be; logic [31:0] a, wd, ld; logic we; int lat; bit st, hs;
        run_access(0, 1, SIZE_B, 0, 32'h0001, 32'h0000_00A5, 32'h0, 3, be, a, wd, we, ld, lat, st, hs);
        checks++; if (be !== 4'b0010 || we !== 1'b1) begin errors++; $display("FAIL sb_be got %b we %b exp 0010 we 1", be, we); end
        checks++; if (wd !== 32'h0000_A500) begin errors++; $display("FAIL sb_wdata got %h exp 0000a500", wd); end
        checks++; if (!st) begin errors++; $display("FAIL sb_stable got changed exp held until gnt"); end
        checks++; if (lat !== 6 || !hs) begin errors++; $display("FAIL sb_latency got %0d hs %b exp 6 hs 1", lat, hs); end
        checks++; if (ld !== 32'h0) begin errors++; $display("FAIL sb_load_data got %h exp 0", ld); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0] be; logic [31:0] a, wd, ld; logic we; int lat; bit st, hs;
        run_access(0, 1, SIZE_W, 0, 32'h0004, 32'hDEAD_BEEF, 32'h0, 0, be, a, wd, we, ld, lat, st, hs);
        checks++; if (be !== 4'b1111 || wd !== 32'hDEAD_BEEF || a !== 32'h4) begin errors++; $display("FAIL sw_fields got %b %h %h exp 1111 deadbeef 00000004", be, wd, a); end
        checks++; if (lat !== 3 || !hs) begin errors++; $display("FAIL sw_latency got %0d hs %b exp 3 hs 1", lat, hs); end
        mem_read = 1; d_size = SIZE_W; addr = 32'h0008; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_done_stall got %b exp 0", stall); end
        step();
        checks++; if (stall !== 1'b1 || bus.req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle got stall=%b req=%b done=%b exp 1 0 0", stall, bus.req, done); end
        run_access(1, 0, SIZE_W, 0, 32'h0008, 32'h0, 32'h1234_5678, 0, be, a, wd, we, ld, lat, st, hs);
        checks++; if (ld !== 32'h1234_5678 || a !== 32'h8 || lat !== 4) begin errors++; $display("FAIL b2b_lw got %h %h lat %0d exp 12345678 00000008 lat 4", ld, a, lat); end
        step();
        run_access(1, 1, SIZE_W, 0, 32'h0020, 32'h5555_5555, 32'h0BAD_F00D, 0, be, a, wd, we, ld, lat, st, hs);
        checks++; if (we !== 1'b0 || ld !== 32'h0BAD_F00D) begin errors++; $display("FAIL rd_priority got we=%b %h exp we=0 0badf00d", we, ld); end
        step();
    endtask

    task automatic test_invalid_size();
        bit bad = 0;
        mem_read = 1; d_size = 4'b0000; addr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (stall !== 1'b0 || bus.req !== 1'b0 || done !== 1'b0) bad = 1;
            step();
        end
        mem_read = 0; mem_write = 1;
        step();
        if (stall !== 1'b0 || bus.req !== 1'b0 || done !== 1'b0) bad = 1;
        mem_write = 0;
        checks++; if (bad) begin errors++; $display("FAIL size0_noaccess got activity exp none"); end
    endtask

    task automatic test_reset_mid_op();
        bit bad = 0;
        mem_read = 1; d_size = SIZE_W; addr = 32'h10;
        step();
        checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL rst_req_pre got %b exp 1", bus.req); end
        rst = 1; mem_read = 0; d_size = 0; #1;
        checks++; if (bus.req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_req_async got req=%b stall=%b exp 0 0", bus.req, stall); end
        step(); rst = 0;
        mem_read = 1; d_size = SIZE_W; addr = 32'h14;
        step();
        bus.gnt = 1; step(); bus.gnt = 0;
        mem_read = 0; d_size = 0;
        rst = 1; #1;
        checks++; if ({stall, done, bus.req, bus.be, bus.addr, load_data} !== '0) begin errors++; $display("FAIL rst_wait_r got stall=%b done=%b addr=%h exp all 0", stall, done, bus.addr); end
        step(); rst = 0;
        bus.rvalid = 1; bus.rdata = 32'hCAFE_F00D;
        step();
        bus.rvalid = 0;
        for (int i = 0; i < 3; i++) begin
            if (done !== 1'b0 || stall !== 1'b0 || load_data !== 32'h0) bad = 1;
            step();
        end
        checks++; if (bad) begin errors++; $display("FAIL stale_rvalid got done/data exp ignored"); end
    endtask

    task automatic test_misalign();
`ifdef DMEM_MISALIGN_TRAP_EN
        mem_read = 1; d_size = SIZE_W; addr = 32'h0006; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall got %b exp 0", stall); end
        step();
        mem_read = 0; d_size = 0;
        checks++; if (misaligned !== 1'b1 || bus.req !== 1'b0) begin errors++; $display("FAIL mis_pulse got mis=%b req=%b exp 1 0", misaligned, bus.req); end
        step();
        checks++; if (misaligned !== 1'b0 || done !== 1'b0 || bus.req !== 1'b0) begin errors++; $display("FAIL mis_end got mis=%b done=%b exp 0 0", misaligned, done); end
`else
        logic [3:0] be; logic [31:0] a, wd, ld; logic we; int lat; bit st, hs;
        run_access(1, 0, SIZE_W, 0, 32'h0006, 32'h0, 32'hAABB_CCDD, 0, be, a, wd, we, ld, lat, st, hs);
        checks++; if (be !== 4'b1100 || a !== 32'h4) begin errors++; $display("FAIL mis_be got %b %h exp 1100 00000004", be, a); end
        checks++; if (ld !== 32'h0000_AABB || misaligned !== 1'b0) begin errors++; $display("FAIL mis_data got %h mis %b exp 0000aabb 0", ld, misaligned); end
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half();
        test_store_delayed_gnt();
        test_back_to_back();
        test_invalid_size();
        test_reset_mid_op();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
